instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 40 ++++
 rtl/imem.sv | 36 +++
 rtl/instr_fetch.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch slice:
//   DEF_WIDTH / DEF_DEPTH : default instruction width and memory depth
//   fetch_state_t         : LOAD / RUN / DONE state encoding
//   NOP_BIT               : fill bit of the NOP word (NOP is all zeros)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // The NOP word is this bit replicated across the instruction width.
  localparam logic NOP_BIT = 1'b0;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the program-load, hazard-control and IF/ID signals of instr_fetch.
//   master : drives load_mode/load_valid/load_data/stall/flush/branch_target,
//            observes pc/ifid_instr/ifid_pc/ifid_valid/load_full/done
//   slave  : the fetch unit (opposite directions)
// -----------------------------------------------------------------------------
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             load_mode;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             stall;
  logic             flush;
  logic [AW-1:0]    branch_target;

  logic [AW-1:0]    pc;
  logic [WIDTH-1:0] ifid_instr;
  logic [AW-1:0]    ifid_pc;
  logic             ifid_valid;
  logic             load_full;
  logic             done;

  modport master (
    output load_mode, load_valid, load_data, stall, flush, branch_target,
    input  pc, ifid_instr, ifid_pc, ifid_valid, load_full, done
  );

  modport slave (
    input  load_mode, load_valid, load_data, stall, flush, branch_target,
    output pc, ifid_instr, ifid_pc, ifid_valid, load_full, done
  );

endinterface

// File: rtl/imem.sv
// -----------------------------------------------------------------------------
// imem
// DEPTH x WIDTH instruction register file, one synchronous write port and one
// combinational read port. Contents are never reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// -----------------------------------------------------------------------------
module imem
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Program-loadable instruction fetch stage with an IF/ID pipeline register.
// LOAD fills imem sequentially; RUN fetches one word per cycle from pc with a
// one-cycle latency onto IF/ID; DONE parks after the last program word.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : instr_fetch_if.slave
//                in : load_mode, load_valid, load_data, stall, flush,
//                     branch_target
//                out: pc, ifid_instr, ifid_pc, ifid_valid, load_full, done
// -----------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_fetch_if.slave bus
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] NOP      = {WIDTH{NOP_BIT}};

  fetch_state_t     r_state;
  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    r_load_ptr;
  logic [AW:0]      r_prog_len;
  logic [WIDTH-1:0] r_ifid_instr;
  logic [AW-1:0]    r_ifid_pc;
  logic             r_ifid_valid;
  logic             r_load_full;
  logic             r_done;

  logic             w_we;
  logic [WIDTH-1:0] w_rdata;
  logic             w_last;
  logic             w_tgt_beyond;
  logic             w_to_load;

  // Loads are accepted only in LOAD and only until the memory is full.
  assign w_we         = (r_state == ST_LOAD) && bus.load_valid && !r_load_full;
  // prog_len is nonzero whenever RUN is active, so the subtraction is safe.
  assign w_last       = ({1'b0, r_pc} == (r_prog_len - 1'b1));
  assign w_tgt_beyond = ({1'b0, bus.branch_target} >= r_prog_len);
  assign w_to_load    = bus.load_mode && (r_state != ST_LOAD);

  imem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_imem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_load_ptr),
    .i_wdata(bus.load_data),
    .i_raddr(r_pc),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_LOAD;
      r_pc         <= '0;
      r_load_ptr   <= '0;
      r_prog_len   <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_load_full  <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_to_load) begin
      // Re-entering LOAD restarts the program; imem keeps its old words.
      r_state      <= ST_LOAD;
      r_pc         <= '0;
      r_load_ptr   <= '0;
      r_prog_len   <= '0;
      r_ifid_instr <= NOP;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_load_full  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_ifid_valid <= 1'b0;
          if (w_we) begin
            r_load_ptr <= r_load_ptr + 1'b1;
            r_prog_len <= r_prog_len + 1'b1;
            if (r_prog_len == (FULL_LEN - 1'b1)) begin
              r_load_full <= 1'b1;
            end
          end
          if (!bus.load_mode && (r_prog_len != '0)) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (bus.flush) begin
            // Branch redirect wins over a stall and squashes IF/ID.
            r_ifid_instr <= NOP;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
            r_pc         <= bus.branch_target;
            if (w_tgt_beyond) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (!bus.stall) begin
            r_ifid_instr <= w_rdata;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_pc + 1'b1;
            // done rises together with the last word appearing on IF/ID.
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_ifid_valid <= 1'b0;
          r_done       <= 1'b1;
        end

        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.ifid_instr = r_ifid_instr;
  assign bus.ifid_pc    = r_ifid_pc;
  assign bus.ifid_valid = r_ifid_valid;
  assign bus.load_full  = r_load_full;
  assign bus.done       = r_done;

endmodule
